gpr_file_mp: RTL and testbench

Parametrised general-purpose register file for the alioth core: configurable data width, depth, read-port count and write-port count, with a per-register pending-write scoreboard for WAW/RAW stall control and a four-phase debug access port. It sits between decode (read/issue) and the writeback stage(s), and replaces the fixed two-read/one-write register file.

---
 rtl/gpr_file_mp_if.sv | 36 +++
 rtl/gpr_file_mp.sv | 124 ++++++++++++
 tb/tb_gpr_file_mp.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_file_mp_if.sv
// Bundle of the register-file read, write, issue-claim and debug signals.
// The master side is decode/writeback/debug host; the slave side is gpr_file_mp.
interface gpr_file_mp_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*XLEN-1:0]   rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic [NUM_WR-1:0]        we_i;
    logic [NUM_WR*ADDR_W-1:0] waddr_i;
    logic [NUM_WR*XLEN-1:0]   wdata_i;
    logic                     iss_valid_i;
    logic [ADDR_W-1:0]        iss_addr_i;
    logic                     iss_ready_o;
    logic                     dbg_req_i;
    logic                     dbg_we_i;
    logic [ADDR_W-1:0]        dbg_addr_i;
    logic [XLEN-1:0]          dbg_wdata_i;
    logic                     dbg_ack_o;
    logic [XLEN-1:0]          dbg_rdata_o;

    modport master (
        output rd_addr_i, we_i, waddr_i, wdata_i, iss_valid_i, iss_addr_i,
               dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  rd_data_o, rd_busy_o, iss_ready_o, dbg_ack_o, dbg_rdata_o
    );

    modport slave (
        input  rd_addr_i, we_i, waddr_i, wdata_i, iss_valid_i, iss_addr_i,
               dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output rd_data_o, rd_busy_o, iss_ready_o, dbg_ack_o, dbg_rdata_o
    );
endinterface

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with write bypass, pending-write scoreboard for issue
// stalls, and a four-phase debug port that yields to core writeback.
module gpr_file_mp #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic          clk,
    input  logic          rst,
    gpr_file_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    logic [XLEN-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [1:0]          state_q, state_d;
    logic [XLEN-1:0]     dbg_rdata_q, dbg_rdata_d;
    logic                dbg_accept;
    logic                iss_hit;
    logic                iss_ready;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]   rd_busy;

    function automatic logic wr_hit(input logic [NUM_WR-1:0]        we,
                                    input logic [NUM_WR*ADDR_W-1:0] waddr,
                                    input logic [ADDR_W-1:0]        a);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WR; w++)
            if (we[w] && waddr[w*ADDR_W +: ADDR_W] == a) hit = 1'b1;
        return hit;
    endfunction

    // Highest-index matching write port supplies the bypass value.
    function automatic logic [XLEN-1:0] bypass(input logic [NUM_WR-1:0]        we,
                                               input logic [NUM_WR*ADDR_W-1:0] waddr,
                                               input logic [NUM_WR*XLEN-1:0]   wdata,
                                               input logic [ADDR_W-1:0]        a,
                                               input logic [XLEN-1:0]          fallback);
        logic [XLEN-1:0] d;
        d = fallback;
        for (int w = 0; w < NUM_WR; w++)
            if (we[w] && waddr[w*ADDR_W +: ADDR_W] == a) d = wdata[w*XLEN +: XLEN];
        return d;
    endfunction

    assign dbg_accept = (state_q == ST_IDLE) && bus.dbg_req_i && !(|bus.we_i);

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (bus.rd_addr_i[r*ADDR_W +: ADDR_W] != '0) begin
                rd_data[r*XLEN +: XLEN] = bypass(bus.we_i, bus.waddr_i, bus.wdata_i,
                                                 bus.rd_addr_i[r*ADDR_W +: ADDR_W],
                                                 regs_q[bus.rd_addr_i[r*ADDR_W +: ADDR_W]]);
                rd_busy[r] = busy_q[bus.rd_addr_i[r*ADDR_W +: ADDR_W]] &
                             ~wr_hit(bus.we_i, bus.waddr_i, bus.rd_addr_i[r*ADDR_W +: ADDR_W]);
            end
        end
    end

    assign iss_hit   = wr_hit(bus.we_i, bus.waddr_i, bus.iss_addr_i);
    assign iss_ready = (bus.iss_addr_i == '0) || !busy_q[bus.iss_addr_i] || iss_hit;

    // NOTE: blocking '=' here so the claim, applied after the write clears, wins on a same-address collision.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++)
            if (bus.we_i[w]) busy_d[bus.waddr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
        if (bus.iss_valid_i && iss_ready && bus.iss_addr_i != '0)
            busy_d[bus.iss_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_accept) begin
                    state_d = ST_ACK;
                    if (!bus.dbg_we_i)
                        dbg_rdata_d = (bus.dbg_addr_i == '0) ? '0 : regs_q[bus.dbg_addr_i];
                end
            end
            ST_ACK:      state_d = ST_WAIT_REL;
            ST_WAIT_REL: if (!bus.dbg_req_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // NOTE: the array is reset because architectural reset clears every GPR; this rules out mapping it to a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q      <= '0;
            state_q     <= ST_IDLE;
            dbg_rdata_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (bus.we_i[w] && bus.waddr_i[w*ADDR_W +: ADDR_W] != '0)
                    regs_q[bus.waddr_i[w*ADDR_W +: ADDR_W]] <= bus.wdata_i[w*XLEN +: XLEN];
            // Debug is only accepted with no core write pending, so it never collides.
            if (dbg_accept && bus.dbg_we_i && bus.dbg_addr_i != '0)
                regs_q[bus.dbg_addr_i] <= bus.dbg_wdata_i;
            busy_q      <= busy_d;
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.rd_data_o   = rd_data;
    assign bus.rd_busy_o   = rd_busy;
    assign bus.iss_ready_o = iss_ready;
    assign bus.dbg_ack_o   = (state_q == ST_ACK);
    assign bus.dbg_rdata_o = dbg_rdata_q;
endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp: bypass, x0, scoreboard, debug handshake, reset.
module tb_gpr_file_mp;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    gpr_file_mp_if #(.XLEN(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

    gpr_file_mp #(.XLEN(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] we, input logic [4:0] a1, input logic [4:0] a0,
                      input logic [31:0] d1, input logic [31:0] d0);
        bus.we_i    = we;
        bus.waddr_i = {a1, a0};
        bus.wdata_i = {d1, d0};
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
        bus.rd_addr_i = {a1, a0};
    endtask

    task automatic dbg(input logic req, input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.dbg_req_i   = req;
        bus.dbg_we_i    = we;
        bus.dbg_addr_i  = a;
        bus.dbg_wdata_i = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rd(5'd0, 5'd0);
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        bus.iss_valid_i = 1'b0;
        bus.iss_addr_i  = 5'd0;
        dbg(1'b0, 1'b0, 5'd0, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state over every address
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(a));
            bus.iss_addr_i = 5'(a);
            #1;
            check("rst_rd_data",   bus.rd_data_o,   64'h0);
            check("rst_rd_busy",   bus.rd_busy_o,   64'h0);
            check("rst_iss_ready", bus.iss_ready_o, 64'h1);
        end
        check("rst_dbg_ack",   bus.dbg_ack_o,   64'h0);
        check("rst_dbg_rdata", bus.dbg_rdata_o, 64'h0);

        // Dual write to x5: port1 wins, bypass then array
        wr(2'b11, 5'd5, 5'd5, 32'h2222, 32'h1111);
        rd(5'd5, 5'd5);
        #1 check("wr_both_bypass", bus.rd_data_o, {32'h2222, 32'h2222});
        cyc();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 check("wr_both_array", bus.rd_data_o, {32'h2222, 32'h2222});

        // Two ports to distinct registers
        wr(2'b11, 5'd8, 5'd6, 32'h4444, 32'h3333);
        rd(5'd8, 5'd6);
        #1 check("wr_split_bypass", bus.rd_data_o, {32'h4444, 32'h3333});
        cyc();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 check("wr_split_array", bus.rd_data_o, {32'h4444, 32'h3333});

        // x0 is hardwired
        wr(2'b01, 5'd0, 5'd0, 32'h0, 32'hFFFF);
        rd(5'd5, 5'd0);
        #1 check("x0_bypass", bus.rd_data_o, {32'h2222, 32'h0});
        cyc();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 check("x0_array", bus.rd_data_o, {32'h2222, 32'h0});

        // Claim x0: always ready, sets nothing
        bus.iss_valid_i = 1'b1;
        bus.iss_addr_i  = 5'd0;
        #1 check("x0_claim_ready", bus.iss_ready_o, 64'h1);
        cyc();
        bus.iss_valid_i = 1'b0;
        #1 check("x0_claim_busy", bus.rd_busy_o, 64'h0);

        // Claim x7
        bus.iss_valid_i = 1'b1;
        bus.iss_addr_i  = 5'd7;
        rd(5'd7, 5'd7);
        #1 check("claim_ready_free", bus.iss_ready_o, 64'h1);
        cyc();
        bus.iss_valid_i = 1'b0;
        #1 check("claim_busy",  bus.rd_busy_o,   64'h3);
        check("claim_not_ready", bus.iss_ready_o, 64'h0);

        // Writeback of x7 releases it in the same cycle
        wr(2'b01, 5'd0, 5'd7, 32'h0, 32'hABCD);
        #1 check("wb_busy_clr",  bus.rd_busy_o,   64'h0);
        check("wb_ready",        bus.iss_ready_o, 64'h1);
        check("wb_data",         bus.rd_data_o,   {32'hABCD, 32'hABCD});
        cyc();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 check("wb_busy_after", bus.rd_busy_o, 64'h0);

        // Claim and write x7 in one cycle: claim wins
        bus.iss_valid_i = 1'b1;
        wr(2'b01, 5'd0, 5'd7, 32'h0, 32'h1234);
        cyc();
        bus.iss_valid_i = 1'b0;
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 check("claim_wr_busy",  bus.rd_busy_o,   64'h3);
        check("claim_wr_not_ready", bus.iss_ready_o, 64'h0);
        check("claim_wr_data",      bus.rd_data_o,   {32'h1234, 32'h1234});

        // Debug write x3
        dbg(1'b1, 1'b1, 5'd3, 32'hDEAD);
        #1 check("dbgw_no_ack_req_cycle", bus.dbg_ack_o, 64'h0);
        cyc();
        check("dbgw_ack", bus.dbg_ack_o, 64'h1);
        cyc();
        check("dbgw_wait_rel_1", bus.dbg_ack_o, 64'h0);
        cyc();
        check("dbgw_wait_rel_2", bus.dbg_ack_o, 64'h0);
        dbg(1'b0, 1'b0, 5'd0, 32'h0);
        cyc();
        rd(5'd3, 5'd3);
        #1 check("dbgw_array", bus.rd_data_o, {32'hDEAD, 32'hDEAD});

        // Debug read x3
        dbg(1'b1, 1'b0, 5'd3, 32'h0);
        cyc();
        check("dbgr_ack",   bus.dbg_ack_o,   64'h1);
        check("dbgr_rdata", bus.dbg_rdata_o, 64'hDEAD);
        dbg(1'b0, 1'b0, 5'd0, 32'h0);
        cyc();
        cyc();

        // Debug read of x5 held off by four cycles of core writes
        dbg(1'b1, 1'b0, 5'd5, 32'h0);
        wr(2'b01, 5'd0, 5'd10, 32'h0, 32'h55);
        for (int i = 0; i < 4; i++) begin
            #1 check("dbg_blocked", bus.dbg_ack_o, 64'h0);
            cyc();
        end
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 check("dbg_free_cycle", bus.dbg_ack_o, 64'h0);
        cyc();
        check("dbg_late_ack",   bus.dbg_ack_o,   64'h1);
        check("dbg_late_rdata", bus.dbg_rdata_o, 64'h2222);
        dbg(1'b0, 1'b0, 5'd0, 32'h0);
        cyc();
        cyc();

        // Abandoned request: dropped before acceptance, no side effects
        dbg(1'b1, 1'b1, 5'd12, 32'hBAD);
        wr(2'b01, 5'd0, 5'd11, 32'h0, 32'h99);
        cyc();
        dbg(1'b0, 1'b0, 5'd0, 32'h0);
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        cyc();
        rd(5'd11, 5'd12);
        #1 check("abandon_ack",  bus.dbg_ack_o, 64'h0);
        check("abandon_data",    bus.rd_data_o, {32'h99, 32'h0});

        // Reset while ACK with x9 busy
        bus.iss_valid_i = 1'b1;
        bus.iss_addr_i  = 5'd9;
        cyc();
        bus.iss_valid_i = 1'b0;
        dbg(1'b1, 1'b1, 5'd9, 32'h77);
        cyc();
        rd(5'd9, 5'd9);
        #1 check("pre_rst_ack",  bus.dbg_ack_o, 64'h1);
        check("pre_rst_busy",    bus.rd_busy_o, 64'h3);
        check("pre_rst_data",    bus.rd_data_o, {32'h77, 32'h77});
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dbg(1'b0, 1'b0, 5'd0, 32'h0);
        #1 check("post_rst_ack", bus.dbg_ack_o,   64'h0);
        check("post_rst_x9_data", bus.rd_data_o,  64'h0);
        check("post_rst_x9_busy", bus.rd_busy_o,  64'h0);
        check("post_rst_rdata",   bus.dbg_rdata_o, 64'h0);
        rd(5'd7, 5'd5);
        #1 check("post_rst_x7_x5", bus.rd_data_o, 64'h0);
        check("post_rst_x7_busy",  bus.rd_busy_o, 64'h0);
        bus.iss_addr_i = 5'd7;
        #1 check("post_rst_ready", bus.iss_ready_o, 64'h1);

        // FSM back in IDLE: a fresh request acks next cycle
        dbg(1'b1, 1'b0, 5'd9, 32'h0);
        cyc();
        check("post_rst_idle_ack", bus.dbg_ack_o,   64'h1);
        check("post_rst_x9_dbg",   bus.dbg_rdata_o, 64'h0);
        dbg(1'b0, 1'b0, 5'd0, 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
